// File: rtl/fifo_uart_tx.sv
// FIFO read-side drainer: pops one byte at a time and sends it
// as a UART 8N1 frame, LSB first, at BAUD_DIV clocks per bit.
module fifo_uart_tx #(
  parameter int BAUD_DIV  = 868,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_enable_i,
  input  logic                 fifo_empty_i,
  input  logic [7:0]           fifo_rd_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 txd_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] frame_count_o
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 rd_en_q, rd_en_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 baud_last;

  assign baud_last = (baud_q == BW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    rd_en_d = rd_en_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (tx_enable_i && !fifo_empty_i) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end
      end
      S_POP: begin
        rd_en_d = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = fifo_rd_data_i;
        txd_d   = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            // next bit is shift_q[1] before the shift lands
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      rd_en_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      rd_en_q <= rd_en_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rd_en_o  = rd_en_q;
  assign txd_o         = txd_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_count_o = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small behavioural
// standard-mode FIFO on the read side (BAUD_DIV=4, CNT_WIDTH=4).
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] rd_data = 8'h00;
  logic       rd_en;
  logic       txd;
  logic       busy;
  logic [3:0] fcnt;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underflow = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .BAUD_DIV (4),
    .CNT_WIDTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_enable_i   (tx_en),
    .fifo_empty_i  (fifo_empty),
    .fifo_rd_data_i(rd_data),
    .fifo_rd_en_o  (rd_en),
    .txd_o         (txd),
    .busy_o        (busy),
    .frame_count_o (fcnt)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      if (rd_ptr == wr_ptr) begin
        underflow <= underflow + 1;
      end else begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rd(input int lim, output int n);
    n = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (rd_en) begin
        n = i;
        break;
      end
    end
    chk("rd_seen", int'(n != 0), 1);
  endtask

  task automatic quiet(input int cyc, input string tag);
    int seen;
    seen = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (rd_en) seen++;
    end
    chk(tag, seen, 0);
  endtask

  // entered on the negedge where rd_en is first seen high
  task automatic recv(output logic [7:0] b);
    b = 8'h00;
    @(negedge clk);
    chk("rd_width", int'(rd_en), 0);
    chk("load_txd", int'(txd), 1);
    @(negedge clk);
    chk("start_bit", int'(txd), 0);
    chk("busy_frame", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = txd;
    end
    repeat (4) @(negedge clk);
    chk("stop_bit", int'(txd), 1);
    repeat (4) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_txd", int'(txd), 1);
  endtask

  initial begin
    int n;
    logic [7:0] b;

    // 1: reset values, then no pop while empty
    repeat (5) @(negedge clk);
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_cnt", int'(fcnt), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    tx_en = 1'b1;
    quiet(200, "no_pop_empty");

    // 2: single 0xA5 frame
    push(8'hA5);
    wait_rd(20, n);
    chk("pop_latency", n, 1);
    recv(b);
    chk("byte_a5", int'(b), 8'hA5);
    chk("cnt_t2", int'(fcnt), 1);

    // 3: back-to-back preload, 43-cycle pop spacing
    tx_en = 1'b0;
    do_reset();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    tx_en = 1'b1;
    wait_rd(20, n);
    recv(b);
    chk("byte_00", int'(b), 8'h00);
    wait_rd(20, n);
    chk("gap_1", n, 1);
    recv(b);
    chk("byte_ff", int'(b), 8'hFF);
    wait_rd(20, n);
    chk("gap_2", n, 1);
    recv(b);
    chk("byte_3c", int'(b), 8'h3C);
    chk("cnt_t3", int'(fcnt), 3);
    chk("empty_t3", int'(fifo_empty), 1);
    quiet(60, "no_pop_drained");

    // 4: TxEnable drop mid-frame
    push(8'h81);
    push(8'h6E);
    wait_rd(20, n);
    tx_en = 1'b0;
    recv(b);
    chk("byte_81", int'(b), 8'h81);
    quiet(60, "no_pop_disabled");
    chk("empty_t4", int'(fifo_empty), 0);
    chk("cnt_t4a", int'(fcnt), 4);
    tx_en = 1'b1;
    wait_rd(20, n);
    chk("resume_latency", n, 1);
    recv(b);
    chk("byte_6e", int'(b), 8'h6E);
    chk("cnt_t4b", int'(fcnt), 5);

    // 5: reset during data bit 3 (bit 3 of 0x52 is 0)
    push(8'h52);
    push(8'hC3);
    wait_rd(20, n);
    repeat (18) @(negedge clk);
    chk("bit3_low", int'(txd), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_txd", int'(txd), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd_en", int'(rd_en), 0);
    chk("arst_cnt", int'(fcnt), 0);
    repeat (3) @(negedge clk);
    chk("arst_hold_txd", int'(txd), 1);
    rst_n = 1'b1;
    wait_rd(20, n);
    chk("post_rst_latency", n, 1);
    recv(b);
    chk("byte_c3", int'(b), 8'hC3);
    chk("cnt_t5", int'(fcnt), 1);

    // 6: 17 frames wrap a 4-bit counter
    tx_en = 1'b0;
    do_reset();
    for (int k = 0; k < 17; k++) push(8'(k * 13 + 7));
    tx_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wait_rd(20, n);
      recv(b);
      chk("byte_wrap", int'(b), (k * 13 + 7) % 256);
      if (k == 14) chk("cnt_ones", int'(fcnt), 15);
      if (k == 15) chk("cnt_wrap0", int'(fcnt), 0);
    end
    chk("cnt_wrap1", int'(fcnt), 1);
    chk("underflow", underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
